btn_debouncer: RTL and testbench

//   Conditions raw push-button inputs before they reach board logic such as
//   the gate and LED exercises.
//   - Synchronises each asynchronous BTN bit to CLK.
//   - Debounces it with a per-button stability counter.
//   - Presents a clean level plus one-cycle press and release strobes per button.

---
 rtl/btn_debouncer_pkg.sv | 21 ++
 rtl/btn_debouncer_if.sv | 12 +
 rtl/btn_debounce_ch.sv | 56 +++++
 rtl/btn_debouncer.sv | 35 +++
 tb/tb_btn_debouncer.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/btn_debouncer_pkg.sv
// btn_debouncer_pkg: board timing defaults and shared channel types for the button debouncer
package btn_debouncer_pkg;

    localparam int BOARD_CLK_HZ = 50_000_000;
    localparam int DEBOUNCE_MS  = 10;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

    localparam int DEFAULT_STABLE_CYCLES = ms_to_cycles(BOARD_CLK_HZ, DEBOUNCE_MS);
    localparam int DEFAULT_CNT_W         = 20;

    // Registered outputs of one debounced channel ('rel' because 'release' is reserved)
    typedef struct packed {
        logic clean;
        logic press;
        logic rel;
    } ch_out_t;

endpackage

// File: rtl/btn_debouncer_if.sv
// btn_debouncer_if: raw button pins in, debounced level and edge strobes out
interface btn_debouncer_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] BTN;
    logic [N_BTN-1:0] BTN_CLEAN;
    logic [N_BTN-1:0] BTN_PRESS;
    logic [N_BTN-1:0] BTN_RELEASE;

    modport master (output BTN, input BTN_CLEAN, input BTN_PRESS, input BTN_RELEASE);
    modport slave  (input BTN, output BTN_CLEAN, output BTN_PRESS, output BTN_RELEASE);
endinterface

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: two-flop synchroniser, stability counter and press/release strobes for one button
module btn_debounce_ch
    import btn_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic    CLK,
    input  logic    RESET,
    input  logic    btn,
    output ch_out_t out
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             differ, at_last, accept;

    // Next state: count consecutive cycles where the synchronised input disagrees with the clean level
    always_comb begin
        s1_d      = btn;
        s2_d      = s1_q;
        differ    = s2_q != clean_q;
        at_last   = cnt_q == CNT_LAST;
        accept    = differ && at_last;
        cnt_d     = (!differ || at_last) ? '0 : cnt_q + 1'b1;
        clean_d   = accept ? s2_q : clean_q;
        press_d   = accept && s2_q;
        rel_d     = accept && !s2_q;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign out = '{clean: clean_q, press: press_q, rel: rel_q};

endmodule

// File: rtl/btn_debouncer.sv
// btn_debouncer: N_BTN independent debounced button channels
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int N_BTN         = 2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input logic             CLK,
    input logic             RESET,
    btn_debouncer_if.slave  bus
);
    logic [N_BTN-1:0] clean_w, press_w, rel_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        ch_out_t o;
        btn_debounce_ch #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W(CNT_W)
        ) u_ch (
            .CLK(CLK),
            .RESET(RESET),
            .btn(bus.BTN[i]),
            .out(o)
        );
        assign clean_w[i] = o.clean;
        assign press_w[i] = o.press;
        assign rel_w[i]   = o.rel;
    end

    assign bus.BTN_CLEAN   = clean_w;
    assign bus.BTN_PRESS   = press_w;
    assign bus.BTN_RELEASE = rel_w;

endmodule

// File: tb/tb_btn_debouncer.sv
// tb_btn_debouncer: directed checks of the debouncer with STABLE_CYCLES=4, CNT_W=3, N_BTN=2
module tb_btn_debouncer;
    logic CLK;
    logic RESET;
    int   total = 0;
    int   bad = 0;
    int   strobes = 0;
    int   s0;
    logic [1:0] pc = 2'b00, pp = 2'b00, pr = 2'b00;

    btn_debouncer_if #(.N_BTN(2)) bif ();

    btn_debouncer #(.N_BTN(2), .STABLE_CYCLES(4), .CNT_W(3)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bif)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [1:0] c, input logic [1:0] p, input logic [1:0] r);
        chk({tag, ".clean"}, bif.BTN_CLEAN, c);
        chk({tag, ".press"}, bif.BTN_PRESS, p);
        chk({tag, ".release"}, bif.BTN_RELEASE, r);
    endtask

    // Invariants sampled mid-cycle: exclusive strobes, strobes match clean edges, one-cycle width, counter bound
    always @(negedge CLK) begin
        if (!RESET) begin
            total++;
            assert ((bif.BTN_PRESS & bif.BTN_RELEASE) == 2'b00) else begin
                bad++;
                $error("FAIL excl observed=%b expected=00", bif.BTN_PRESS & bif.BTN_RELEASE);
            end
            total++;
            assert ((bif.BTN_PRESS & ~(bif.BTN_CLEAN & ~pc)) == 2'b00) else begin
                bad++;
                $error("FAIL press_rise observed=%b expected=00", bif.BTN_PRESS & ~(bif.BTN_CLEAN & ~pc));
            end
            total++;
            assert ((bif.BTN_RELEASE & ~(~bif.BTN_CLEAN & pc)) == 2'b00) else begin
                bad++;
                $error("FAIL release_fall observed=%b expected=00", bif.BTN_RELEASE & ~(~bif.BTN_CLEAN & pc));
            end
            total++;
            assert (((bif.BTN_PRESS & pp) | (bif.BTN_RELEASE & pr)) == 2'b00) else begin
                bad++;
                $error("FAIL width observed=%b expected=00", (bif.BTN_PRESS & pp) | (bif.BTN_RELEASE & pr));
            end
            total++;
            assert (dut.g_ch[0].u_ch.cnt_q <= 3'd3 && dut.g_ch[1].u_ch.cnt_q <= 3'd3) else begin
                bad++;
                $error("FAIL cnt_bound observed=%0d,%0d expected<=3", dut.g_ch[0].u_ch.cnt_q, dut.g_ch[1].u_ch.cnt_q);
            end
        end
        strobes += $countones(bif.BTN_PRESS | bif.BTN_RELEASE);
        pc = bif.BTN_CLEAN;
        pp = bif.BTN_PRESS;
        pr = bif.BTN_RELEASE;
    end

    initial begin
        RESET = 1'b1;
        bif.BTN = 2'b11;
        tick(3);
        outs("rst", 2'b00, 2'b00, 2'b00);
        RESET = 1'b0;
        tick(5);
        outs("rst_e5", 2'b00, 2'b00, 2'b00);
        tick(1);
        outs("rst_e6", 2'b11, 2'b11, 2'b00);
        tick(1);
        outs("rst_e7", 2'b11, 2'b00, 2'b00);
        bif.BTN = 2'b00;
        tick(6);
        outs("rel_all", 2'b00, 2'b00, 2'b11);
        tick(1);
        bif.BTN = 2'b01;
        tick(5);
        outs("press_e4", 2'b00, 2'b00, 2'b00);
        tick(1);
        outs("press_e5", 2'b01, 2'b01, 2'b00);
        tick(1);
        outs("press_e6", 2'b01, 2'b00, 2'b00);
        bif.BTN = 2'b00;
        tick(5);
        outs("release_e4", 2'b01, 2'b00, 2'b00);
        tick(1);
        outs("release_e5", 2'b00, 2'b00, 2'b01);
        tick(1);
        outs("release_e6", 2'b00, 2'b00, 2'b00);
        s0 = strobes;
        for (int k = 0; k < 4; k++) begin
            bif.BTN = (k % 2 == 0) ? 2'b01 : 2'b00;
            tick(2);
        end
        bif.BTN = 2'b01;
        tick(5);
        chk("bounce.strobes", 2'(strobes - s0), 2'd0);
        outs("bounce_e4", 2'b00, 2'b00, 2'b00);
        tick(1);
        outs("bounce_e5", 2'b01, 2'b01, 2'b00);
        tick(1);
        s0 = strobes;
        bif.BTN = 2'b11;
        tick(3);
        bif.BTN = 2'b01;
        tick(10);
        chk("glitch.strobes", 2'(strobes - s0), 2'd0);
        outs("glitch", 2'b01, 2'b00, 2'b00);
        bif.BTN = 2'b00;
        tick(8);
        outs("idle", 2'b00, 2'b00, 2'b00);
        bif.BTN = 2'b11;
        tick(5);
        outs("simul_e4", 2'b00, 2'b00, 2'b00);
        tick(1);
        outs("simul_e5", 2'b11, 2'b11, 2'b00);
        tick(2);
        s0 = strobes;
        bif.BTN = 2'b10;
        tick(5);
        outs("rel0_e4", 2'b11, 2'b00, 2'b00);
        tick(1);
        outs("rel0_e5", 2'b10, 2'b00, 2'b01);
        tick(3);
        chk("rel0.strobes", 2'(strobes - s0), 2'd1);
        outs("rel0_after", 2'b10, 2'b00, 2'b00);
        s0 = strobes;
        bif.BTN = 2'b11;
        tick(3);
        RESET = 1'b1;
        tick(1);
        outs("midrst", 2'b00, 2'b00, 2'b00);
        RESET = 1'b0;
        tick(5);
        chk("midrst.strobes", 2'(strobes - s0), 2'd0);
        outs("midrst_e4", 2'b00, 2'b00, 2'b00);
        tick(1);
        outs("midrst_e5", 2'b11, 2'b11, 2'b00);
        tick(1);
        outs("midrst_e6", 2'b11, 2'b00, 2'b00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
